// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM and a word-addressed data memory.
// Stores are accepted in one cycle and drained in order, one per cycle, on
// cycles where no load owns the memory port. Loads forward from the youngest
// matching buffered entry.
// Optional feature: define STORE_COALESCE_EN to merge a store into the
// youngest entry when their word addresses match.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdat,
  input  logic [31:0]      st_pc,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic [31:0]      ld_rdat,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdat,
  output logic [31:0]      mem_wpc,
  output logic             mem_write,
  input  logic [31:0]      mem_rdat,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] OneCnt  = (PTR_W + 1)'(1);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      wdat_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0] young_idx;
  logic             coal_hit;
  logic             push;
  logic             alloc;
  logic             drain;

  // Push/drain/coalesce decisions, all from registered state.
  always_comb begin
    young_idx = tail_q - PTR_W'(1);
    drain     = (count_q != '0) && !ld_valid;
`ifdef STORE_COALESCE_EN
    // The youngest entry can only be the draining head when it is the sole entry.
    coal_hit  = (count_q != '0) && (addr_q[young_idx] == st_addr[31:2]) &&
                !((count_q == OneCnt) && drain);
`else
    coal_hit  = 1'b0;
`endif
    st_ready  = (count_q != FullCnt) || coal_hit;
    push      = st_valid && st_ready;
    alloc     = push && !coal_hit;
  end

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = drain ? head_q + PTR_W'(1) : head_q;
    tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + (PTR_W + 1)'(alloc) - (PTR_W + 1)'(drain);
  end

  // Control state with asynchronous clear; pending stores are discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= st_addr[31:2];
      wdat_q[tail_q] <= st_wdat;
      pc_q[tail_q]   <= st_pc;
    end else if (push && coal_hit) begin
      wdat_q[young_idx] <= st_wdat;
      pc_q[young_idx]   <= st_pc;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    ld_rdat = mem_rdat;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (((PTR_W + 1)'(i) < count_q) && (addr_q[idx] == ld_addr[31:2])) begin
        ld_rdat = wdat_q[idx];
      end
    end
  end

  // Memory port: a load owns the address, otherwise it shows the head slot.
  always_comb begin
    mem_write = drain;
    mem_addr  = ld_valid ? ld_addr : {addr_q[head_q], 2'b00};
    mem_wdat  = wdat_q[head_q];
    mem_wpc   = pc_q[head_q];
    empty     = (count_q == '0);
    count     = count_q;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based reference model checked
// on every falling edge, directed scenarios with literal expectations, and a
// randomized phase.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             st_valid = 1'b0;
  logic             st_ready;
  logic [31:0]      st_addr = '0;
  logic [31:0]      st_wdat = '0;
  logic [31:0]      st_pc = '0;
  logic             ld_valid = 1'b0;
  logic [31:0]      ld_addr = '0;
  logic [31:0]      ld_rdat;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdat;
  logic [31:0]      mem_wpc;
  logic             mem_write;
  logic [31:0]      mem_rdat = 32'h1234_5678;
  logic             empty;
  logic [PTR_W:0]   count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_wdat   (st_wdat),
    .st_pc     (st_pc),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_rdat   (ld_rdat),
    .mem_addr  (mem_addr),
    .mem_wdat  (mem_wdat),
    .mem_wpc   (mem_wpc),
    .mem_write (mem_write),
    .mem_rdat  (mem_rdat),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [31:0] la, input logic [31:0] mr);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == la[31:2]) return q[i].d;
    end
    return mr;
  endfunction

  // Compare DUT against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
    end else begin
      bit exp_mw, exp_rdy, match, coal;
      int n;
      n       = q.size();
      exp_mw  = (n != 0) && !ld_valid;
      match   = 1'b0;
`ifdef STORE_COALESCE_EN
      match   = (n != 0) && (q[n-1].a == st_addr[31:2]) && !((n == 1) && exp_mw);
`endif
      exp_rdy = (n != DEPTH) || match;
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("st_ready", 32'(st_ready), 32'(exp_rdy));
      chk("mem_write", 32'(mem_write), 32'(exp_mw));
      if (ld_valid) begin
        chk("mem_addr_ld", mem_addr, ld_addr);
        chk("ld_rdat", ld_rdat, fwd(ld_addr, mem_rdat));
      end
      if (exp_mw) begin
        chk("mem_addr_drain", mem_addr, {q[0].a, 2'b00});
        chk("mem_wdat", mem_wdat, q[0].d);
        chk("mem_wpc", mem_wpc, q[0].pc);
      end
      coal = st_valid && exp_rdy && match;
      if (coal) begin
        q[n-1].d  = st_wdat;
        q[n-1].pc = st_pc;
      end
      if (exp_mw) void'(q.pop_front());
      if (st_valid && exp_rdy && !coal) q.push_back({st_addr[31:2], st_wdat, st_pc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdat  = d;
    st_pc    = 32'h0000_4000 + a;
  endtask

  initial begin
    #12 rst = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_mw", 32'(mem_write), 32'd0);
      chk("idle_rdy", 32'(st_ready), 32'd1);
    end

    // Single store drains the next cycle.
    tick(); store(32'h100, 32'hAAAA_0001); #2;
    chk("s1_mw0", 32'(mem_write), 32'd0);
    tick(); st_valid = 1'b0; #2;
    chk("s1_mw", 32'(mem_write), 32'd1);
    chk("s1_addr", mem_addr, 32'h100);
    chk("s1_wdat", mem_wdat, 32'hAAAA_0001);
    chk("s1_wpc", mem_wpc, 32'h0000_4100);
    tick(); #2;
    chk("s1_empty", 32'(empty), 32'd1);

    // Fill while a load blocks draining, then drain in order.
    ld_valid = 1'b1; ld_addr = 32'h800;
    for (int i = 0; i < 4; i++) begin
      tick(); store(32'(4 * i), 32'hB000_0000 + 32'(i));
    end
    tick(); store(32'h10, 32'hB000_0004); #2;
    chk("full_count", 32'(count), 32'd4);
    chk("full_rdy", 32'(st_ready), 32'd0);
    tick(); #2;
    chk("held_count", 32'(count), 32'd4);
    tick(); st_valid = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      #2;
      chk("order_addr", mem_addr, 32'(4 * i));
      chk("order_wdat", mem_wdat, 32'hB000_0000 + 32'(i));
    end
    tick(); #2;
    chk("order_empty", 32'(empty), 32'd1);

    // Forwarding of the youngest matching store.
    ld_valid = 1'b1; ld_addr = 32'hFFF0;
    tick(); store(32'h20, 32'd1);
    tick(); store(32'h20, 32'd2);
    tick(); st_valid = 1'b0; ld_addr = 32'h22; #2;
    chk("fwd_data", ld_rdat, 32'd2);
`ifdef STORE_COALESCE_EN
    chk("fwd_count", 32'(count), 32'd1);
`else
    chk("fwd_count", 32'(count), 32'd2);
`endif
    tick(); ld_addr = 32'h24; mem_rdat = 32'h55; #2;
    chk("fwd_miss", ld_rdat, 32'h55);
    tick(); ld_valid = 1'b0;
    repeat (3) tick();

    // Steady push+drain with two entries held; wraps both pointers.
    ld_valid = 1'b1;
    tick(); store(32'h300, 32'hC000_0000);
    tick(); store(32'h304, 32'hC000_0001);
    for (int i = 0; i < 8; i++) begin
      tick(); ld_valid = 1'b0; store(32'h308 + 32'(4 * i), 32'hC000_0002 + 32'(i)); #2;
      chk("pd_count", 32'(count), 32'd2);
      chk("pd_addr", mem_addr, 32'h300 + 32'(4 * i));
    end
    tick(); st_valid = 1'b0;
    repeat (3) tick();

    // Asynchronous reset with pending stores.
    ld_valid = 1'b1; ld_addr = 32'h900;
    for (int i = 0; i < 3; i++) begin
      tick(); store(32'h500 + 32'(4 * i), 32'hD000_0000 + 32'(i));
    end
    tick(); st_valid = 1'b0; #2;
    chk("rst_pre", 32'(count), 32'd3);
    ld_valid = 1'b0; rst = 1'b0; #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mw", 32'(mem_write), 32'd0);
    tick(); rst = 1'b1;
    tick(); #2;
    chk("rst_post_mw", 32'(mem_write), 32'd0);
    chk("rst_post_empty", 32'(empty), 32'd1);

`ifdef STORE_COALESCE_EN
    ld_valid = 1'b1; ld_addr = 32'h40;
    tick(); store(32'h40, 32'hE000_0001);
    tick(); store(32'h40, 32'hE000_0002);
    tick(); st_valid = 1'b0; #2;
    chk("coal_count", 32'(count), 32'd1);
    chk("coal_data", ld_rdat, 32'hE000_0002);
    tick(); ld_valid = 1'b0;
    repeat (2) tick();
`endif

    // Randomized traffic over a small address window to exercise forwarding.
    for (int i = 0; i < 1500; i++) begin
      tick();
      st_valid = ($urandom_range(0, 99) < 60);
      st_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      st_wdat  = $urandom;
      st_pc    = $urandom;
      ld_valid = ($urandom_range(0, 99) < 35);
      ld_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      mem_rdat = $urandom;
    end
    tick(); st_valid = 1'b0; ld_valid = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM stage and the word-addressed data memory.
- Accepts word stores from MEM in one cycle and drains them to memory in order, one per cycle, using cycles when no load needs the memory port.
- Loads see the youngest buffered value for their word address, so memory semantics are preserved.
- Stalls MEM only when full.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- st_valid  input  1  MEM presents a store this cycle.
- st_ready  output  1  buffer can accept a store; equals (count != DEPTH).
- st_addr  input  32  store byte address; bits [1:0] ignored.
- st_wdat  input  32  store data.
- st_pc  input  32  PC of the store instruction, carried to memory for trace.
- ld_valid  input  1  MEM performs a load this cycle.
- ld_addr  input  32  load byte address.
- ld_rdat  output  32  load result: forwarded entry data or mem_rdat.
- mem_addr  output  32  memory address: ld_addr when ld_valid, else head entry address.
- mem_wdat  output  32  head entry data.
- mem_wpc  output  32  head entry PC.
- mem_write  output  1  drain strobe to memory.
- mem_rdat  input  32  memory combinational read data.
- empty  output  1  count == 0; used before syscall/halt.
- count  output  PTR_W+1  occupied entries.

Behaviour:
- Storage:
  - DEPTH entries of {addr[31:2], wdat, pc}.
  - Circular buffer with head and tail pointers of PTR_W bits that wrap modulo DEPTH.
  - count is a separate PTR_W+1 register.
- Reset (rst low, asynchronous):
  - head=0, tail=0, count=0.
  - Entry contents do not matter after reset.
  - Consequently mem_write=0, empty=1, st_ready=1.
  - Reset mid-drain discards all pending stores; no partial write occurs after rst falls.
- Push: st_valid && st_ready at a rising edge writes the entry at tail, then tail+1 and count+1.
- st_valid while full is ignored; MEM must hold the store until st_ready.
- Drain:
  - mem_write = (count != 0) && !ld_valid, combinational.
  - At the edge where mem_write=1, head+1 and count-1.
  - A store pushed at edge N is drained no earlier than cycle N+1.
- Simultaneous push and drain: count unchanged, both pointers advance. This is legal even when the buffer holds DEPTH-1 or 1 entries.
- Full: st_ready is derived from registered count only. A drain in the same cycle does not raise st_ready.
- Load priority: ld_valid blocks drain for that cycle. mem_addr = ld_addr, and mem_write=0.
- Forwarding:
  - ld_rdat is the wdat of the youngest valid entry with addr[31:2] == ld_addr[31:2]. Search runs from tail-1 back toward head.
  - If no entry matches, ld_rdat = mem_rdat.
  - A store accepted at the same edge is not visible to a load in that cycle; the load sees pre-edge contents.
- Ordering: memory is written strictly in acceptance order.
- mem_addr[1:0] = 2'b00 when draining.
- Idle outputs: when mem_write=0 and ld_valid=0, mem_addr/mem_wdat/mem_wpc show the head slot. Their values do not matter.

Optional Feature:
- STORE_COALESCE_EN defined:
  - A store whose word address equals the youngest valid entry's address overwrites that entry's wdat and pc. No allocation: tail and count are unchanged.
  - Coalescing is allowed even when the buffer is full. In that case st_ready = 1 for the matching store.
  - Coalescing does not occur if the youngest entry is the head and is draining in the same cycle; the store then allocates normally.
- Not defined: every accepted store allocates a new entry.

Test Plan:
- Reset release, idle with no stores and no loads -> empty=1, count=0, mem_write=0, st_ready=1 on every cycle.
- Store 0x100<-0xAAAA0001, no loads -> mem_write=1 next cycle with mem_addr=0x100, mem_wdat=0xAAAA0001; empty=1 the cycle after.
- 4 stores to 0x0,0x4,0x8,0xC while ld_valid held high -> count=4, st_ready=0, a 5th store is held; release the load -> drains in order 0x0,0x4,0x8,0xC, one per cycle.
- Stores 0x20<-1 then 0x20<-2 (coalescing off), load 0x22 while both are pending -> ld_rdat=2, count=2; load 0x24 with mem_rdat=0x55 -> ld_rdat=0x55.
- Buffer holds 2 entries, push and drain in the same cycle -> count stays 2, head and tail each +1; repeat over 8 cycles to wrap both pointers with no loss of order.
- Assert rst low for one cycle while 3 entries are pending -> count=0 immediately (asynchronous), no mem_write after release. With STORE_COALESCE_EN: two stores to 0x40 back to back with ld_valid high -> count=1, data = second store.
